// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-and-add-3 binary to BCD converter.
// Optional macro BIN2BCD_LZ_BLANK_EN blanks leading zero digits (4'hF).
module bin2bcd_seq #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(BIN_W);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t          state;
    logic [BIN_W-1:0] sh;
    logic [BW-1:0]   work;
    logic [CW-1:0]   cnt;
    logic            oflag;

    logic [BW-1:0]    adj;
    logic [BW-1:0]    work_nx;
    logic [BIN_W-1:0] sh_nx;
    logic             step_ovf;
    logic [BW-1:0]    res;

    // one double-dabble iteration: add 3 to digits >= 5, then shift left
    always_comb begin
        adj = work;
        for (int i = 0; i < DIGITS; i++) begin
            if (work[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
        end
        {work_nx, sh_nx} = {adj, sh} << 1;
        step_ovf = adj[BW-1];
    end

`ifdef BIN2BCD_LZ_BLANK_EN
    logic lead;

    // final display form: leading zeros blanked, overflow shows all blank
    always_comb begin
        res  = work;
        lead = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            if (lead && work[4*i +: 4] == 4'd0)
                res[4*i +: 4] = 4'hF;
            else
                lead = 1'b0;
        end
        if (oflag)
            res = '1;
    end
`else
    // final display form: overflow shows all blank
    always_comb begin
        res = work;
        if (oflag)
            res = '1;
    end
`endif

    // control FSM; busy stays high through the done cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sh    <= '0;
            work  <= '0;
            cnt   <= '0;
            oflag <= 1'b0;
            bcd   <= '0;
            ovf   <= 1'b0;
            done  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    busy <= start;
                    if (start) begin
                        sh    <= bin;
                        work  <= '0;
                        cnt   <= '0;
                        oflag <= 1'b0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    busy <= 1'b1;
                    sh   <= sh_nx;
                    work <= work_nx;
                    if (step_ovf)
                        oflag <= 1'b1;
                    if (cnt == CW'(BIN_W - 1))
                        state <= DONE;
                    else
                        cnt <= cnt + CW'(1);
                end
                DONE: begin
                    busy  <= 1'b1;
                    bcd   <= res;
                    ovf   <= oflag;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed bench for bin2bcd_seq.
// Covers DIGITS=5 and DIGITS=4 (overflow) instances.
module tb_bin2bcd_seq;

    logic        clk;
    logic        rst_n;
    logic        start0;
    logic        start1;
    logic [15:0] bin0;
    logic [15:0] bin1;
    logic        busy0;
    logic        done0;
    logic [19:0] bcd0;
    logic        ovf0;
    logic        busy1;
    logic        done1;
    logic [15:0] bcd1;
    logic        ovf1;

    int nvec = 0;
    int nerr = 0;

`ifdef BIN2BCD_LZ_BLANK_EN
    localparam logic [19:0] E1234 = 20'hF1234;
    localparam logic [19:0] E0    = 20'hFFFF0;
    localparam logic [19:0] E42   = 20'hFFF42;
    localparam logic [19:0] E500  = 20'hFF500;
    localparam logic [15:0] E42_4 = 16'hFF42;
`else
    localparam logic [19:0] E1234 = 20'h01234;
    localparam logic [19:0] E0    = 20'h00000;
    localparam logic [19:0] E42   = 20'h00042;
    localparam logic [19:0] E500  = 20'h00500;
    localparam logic [15:0] E42_4 = 16'h0042;
`endif

    bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) u0 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start0),
        .bin   (bin0),
        .busy  (busy0),
        .done  (done0),
        .bcd   (bcd0),
        .ovf   (ovf0)
    );

    bin2bcd_seq #(.BIN_W(16), .DIGITS(4)) u1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .bin   (bin1),
        .busy  (busy1),
        .done  (done1),
        .bcd   (bcd1),
        .ovf   (ovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    task automatic run0(input logic [15:0] v,
                        output int lat,
                        output logic b);
        @(negedge clk);
        start0 = 1'b1;
        bin0   = v;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        b   = busy0;
        lat = 0;
        while (done0 !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run1(input logic [15:0] v,
                        output int lat);
        @(negedge clk);
        start1 = 1'b1;
        bin1   = v;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        lat = 0;
        while (done1 !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        int   lat;
        int   nd;
        logic b;

        rst_n  = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        bin0   = '0;
        bin1   = '0;
        #1;
        chk("rst_bcd", bcd0, 0);
        chk("rst_ovf", ovf0, 0);
        chk("rst_done", done0, 0);
        chk("rst_busy", busy0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_busy", busy0, 0);

        run0(16'd1234, lat, b);
        chk("1234_busy_rise", b, 1);
        chk("1234_lat", lat, 17);
        chk("1234_bcd", bcd0, E1234);
        chk("1234_ovf", ovf0, 0);
        chk("1234_busy_ovl", busy0, 1);
        @(posedge clk);
        #1;
        chk("1234_done_drop", done0, 0);
        chk("1234_busy_drop", busy0, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("1234_hold", bcd0, E1234);

        run0(16'd65535, lat, b);
        chk("65535_lat", lat, 17);
        chk("65535_bcd", bcd0, 20'h65535);
        chk("65535_ovf", ovf0, 0);
        run0(16'd0, lat, b);
        chk("b2b_lat", lat, 17);
        chk("zero_bcd", bcd0, E0);
        chk("zero_ovf", ovf0, 0);

        run0(16'd42, lat, b);
        chk("42_bcd", bcd0, E42);
        run0(16'd10005, lat, b);
        chk("10005_bcd", bcd0, 20'h10005);

        @(negedge clk);
        start0 = 1'b1;
        bin0   = 16'd500;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        nd  = 0;
        lat = 0;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            start0 = (c == 3 || c == 16);
            if (c == 3)
                bin0 = 16'd777;
            @(posedge clk);
            #1;
            if (done0) begin
                nd++;
                lat = c;
            end
        end
        start0 = 1'b0;
        chk("busyst_ndone", nd, 1);
        chk("busyst_lat", lat, 17);
        chk("busyst_bcd", bcd0, E500);

        @(negedge clk);
        start0 = 1'b1;
        bin0   = 16'd1234;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        start0 = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_bcd", bcd0, 0);
        chk("arst_ovf", ovf0, 0);
        chk("arst_done", done0, 0);
        chk("arst_busy", busy0, 0);
        @(negedge clk);
        start0 = 1'b0;
        rst_n  = 1'b1;
        nd = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (done0)
                nd++;
        end
        chk("arst_nodone", nd, 0);
        chk("arst_idle", busy0, 0);
        chk("arst_bcd2", bcd0, 0);

        run1(16'd9999, lat);
        chk("9999_lat", lat, 17);
        chk("9999_bcd", bcd1, 16'h9999);
        chk("9999_ovf", ovf1, 0);
        run1(16'd10000, lat);
        chk("10000_lat", lat, 17);
        chk("10000_bcd", bcd1, 16'hFFFF);
        chk("10000_ovf", ovf1, 1);

        @(negedge clk);
        start1 = 1'b1;
        bin1   = 16'd42;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("ovf_hold_bcd", bcd1, 16'hFFFF);
        chk("ovf_hold_ovf", ovf1, 1);
        lat = 5;
        while (done1 !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("42_4_lat", lat, 17);
        chk("42_4_bcd", bcd1, E42_4);
        chk("42_4_ovf", ovf1, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
